// File: rtl/seg_scan_display_if.sv
// Display bus for seg_scan_display: sample request/mode inputs and
// multiplexed digit, segment, LED and status outputs.
interface seg_scan_display_if #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 4,
   parameter int LED_W  = 8
);
   logic [DATA_W-1:0] value;
   logic              load;
   logic              hex_mode;
   logic              add;
   logic              sub;
   logic [DIGITS-1:0] dig;
   logic [6:0]        seg;
   logic [LED_W-1:0]  led;
   logic              busy;
   logic              ovf;

   modport master (
      output value, load, hex_mode, add, sub,
      input  dig, seg, led, busy, ovf
   );

   modport slave (
      input  value, load, hex_mode, add, sub,
      output dig, seg, led, busy, ovf
   );
endinterface

// File: rtl/seg_scan_display.sv
// Samples a value, converts it to hex or signed/unsigned decimal with a serial
// double-dabble engine and scans it onto an active-low 7-segment bus.
// Optional macro SEG_LZB_EN: leading-zero blanking with a floating minus sign.
module seg_scan_display #(
   parameter int DATA_W   = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000,
   parameter int LED_W    = 8
) (
   input logic               CLK,
   input logic               RST,
   seg_scan_display_if.slave bus
);
   localparam int BCD_N = (DATA_W + 2) / 3;
   localparam int PAD_W = 4 * BCD_N;
   localparam int MAX_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [6:0] GLY_0     = 7'b1000000;
   localparam logic [6:0] GLY_E     = 7'b0000110;
   localparam logic [6:0] GLY_MINUS = 7'b0111111;
   localparam logic [6:0] GLY_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, HEX, DEC, FIX} state_t;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = 7'b1111111;
      endcase
   endfunction

   state_t                  state_r, state_nxt_s;
   logic                    accept_s, shift_s, commit_s;
   logic [CNT_W-1:0]        cnt_r;
   logic [DATA_W-1:0]       val_r, bin_r, mag_s, bin_nxt_s;
   logic                    hex_r, sgn_r, neg_s, ovf_s;
   logic [PAD_W-1:0]        bcd_r, adj_s, bcd_nxt_s, src_s;
   logic [4*MAX_N-1:0]      src_w_s;
   logic [DIGITS-1:0][6:0]  disp_r, nxt_disp_s;
   logic [DIGITS-1:0]       one_hot_s;
   logic [PRE_W-1:0]        pre_r;
   logic [IDX_W-1:0]        idx_r;
   int                      lim_s, msd_s;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // FSM next state and control strobes
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      shift_s     = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.load) begin
               accept_s    = 1'b1;
               state_nxt_s = bus.hex_mode ? HEX : DEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HEX: begin
            commit_s    = 1'b1;
            state_nxt_s = IDLE;
         end
         DEC: begin
            shift_s = 1'b1;
            if (cnt_r == CNT_W'(DATA_W - 1)) state_nxt_s = FIX;
            else                             state_nxt_s = DEC;
         end
         FIX: begin
            commit_s    = 1'b1;
            state_nxt_s = IDLE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Magnitude at accept and one double-dabble step
   always_comb begin
      if (bus.sub && !bus.add && bus.value[DATA_W-1]) mag_s = (~bus.value) + DATA_W'(1);
      else                                            mag_s = bus.value;
      adj_s = bcd_r;
      for (int k = 0; k < BCD_N; k++) begin
         if (bcd_r[4*k +: 4] >= 4'd5) adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
         else                         adj_s[4*k +: 4] = bcd_r[4*k +: 4];
      end
      bcd_nxt_s = {adj_s[PAD_W-2:0], bin_r[DATA_W-1]};
      bin_nxt_s = bin_r << 1;
   end

   // Digit source, overflow detection and glyph placement for the commit
   always_comb begin
      src_s   = hex_r ? PAD_W'(val_r) : bcd_r;
      src_w_s = (4*MAX_N)'(src_s);
      neg_s   = !hex_r && sgn_r && val_r[DATA_W-1];
      lim_s   = neg_s ? DIGITS - 1 : DIGITS;
      ovf_s   = 1'b0;
      msd_s   = 0;
      for (int k = 0; k < BCD_N; k++) begin
         if (src_s[4*k +: 4] != 4'd0) begin
            msd_s = k;
            if (k >= lim_s) ovf_s = 1'b1;
            else            ovf_s = ovf_s;
         end else begin
            msd_s = msd_s;
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG_LZB_EN
         if (i <= msd_s)                    nxt_disp_s[i] = glyph(src_w_s[4*i +: 4]);
         else if (neg_s && i == msd_s + 1)  nxt_disp_s[i] = GLY_MINUS;
         else                               nxt_disp_s[i] = GLY_BLANK;
`else
         if (neg_s && i == DIGITS - 1) nxt_disp_s[i] = GLY_MINUS;
         else                          nxt_disp_s[i] = glyph(src_w_s[4*i +: 4]);
`endif
         if (ovf_s) nxt_disp_s[i] = GLY_E;
         else       nxt_disp_s[i] = nxt_disp_s[i];
      end
   end

   // Sample, conversion datapath and atomic display update
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r    <= '0;
         val_r    <= '0;
         hex_r    <= 1'b0;
         sgn_r    <= 1'b0;
         bin_r    <= '0;
         bcd_r    <= '0;
         disp_r   <= {DIGITS{GLY_0}};
         bus.led  <= '0;
         bus.busy <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         bus.busy <= (state_nxt_s != IDLE);
         if (accept_s) begin
            val_r   <= bus.value;
            hex_r   <= bus.hex_mode;
            sgn_r   <= bus.sub && !bus.add;
            bin_r   <= mag_s;
            bcd_r   <= '0;
            cnt_r   <= '0;
            bus.led <= LED_W'(bus.value);
         end else if (shift_s) begin
            bin_r <= bin_nxt_s;
            bcd_r <= bcd_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
         end else if (commit_s) begin
            disp_r  <= nxt_disp_s;
            bus.ovf <= ovf_s;
         end
      end
   end

   // Active-low enable for the current scan slot
   always_comb begin
      one_hot_s = '0;
      for (int i = 0; i < DIGITS; i++) one_hot_s[i] = (idx_r == IDX_W'(i));
   end

   // Prescaler, scan index and registered digit/segment pair
   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_r   <= '0;
         idx_r   <= '0;
         bus.dig <= '1;
         bus.seg <= GLY_BLANK;
      end else begin
         if (pre_r == PRE_W'(SCAN_DIV - 1)) begin
            pre_r <= '0;
            idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
         end else begin
            pre_r <= pre_r + PRE_W'(1);
         end
         bus.dig <= ~one_hot_s;
         bus.seg <= disp_r[idx_r];
      end
   end
endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized self-checking bench for seg_scan_display (8-bit and 16-bit
// instances) against an arithmetic digit model.
module tb_seg_scan_display;
   localparam int D  = 4;
   localparam int SD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value_t = 16'd0;
   logic        load_t = 1'b0, hex_t = 1'b0, add_t = 1'b0, sub_t = 1'b0, sel_t = 1'b0;

   seg_scan_display_if #(.DATA_W(8),  .DIGITS(D), .LED_W(8)) bus8();
   seg_scan_display_if #(.DATA_W(16), .DIGITS(D), .LED_W(8)) bus16();

   assign bus8.value     = value_t[7:0];
   assign bus8.load      = load_t & ~sel_t;
   assign bus8.hex_mode  = hex_t;
   assign bus8.add       = add_t;
   assign bus8.sub       = sub_t;
   assign bus16.value    = value_t;
   assign bus16.load     = load_t & sel_t;
   assign bus16.hex_mode = hex_t;
   assign bus16.add      = add_t;
   assign bus16.sub      = sub_t;

   seg_scan_display #(.DATA_W(8), .DIGITS(D), .SCAN_DIV(SD), .LED_W(8)) dut8 (
      .CLK(clk), .RST(rst), .bus(bus8));
   seg_scan_display #(.DATA_W(16), .DIGITS(D), .SCAN_DIV(SD), .LED_W(8)) dut16 (
      .CLK(clk), .RST(rst), .bus(bus16));

   logic [3:0] dig_m;
   logic [6:0] seg_m;
   logic [7:0] led_m;
   logic       busy_m, ovf_m;
   assign dig_m  = sel_t ? bus16.dig  : bus8.dig;
   assign seg_m  = sel_t ? bus16.seg  : bus8.seg;
   assign led_m  = sel_t ? bus16.led  : bus8.led;
   assign busy_m = sel_t ? bus16.busy : bus8.busy;
   assign ovf_m  = sel_t ? bus16.ovf  : bus8.ovf;

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   logic [6:0] gtab [16];
   logic [6:0] exp_g [D];
   logic       exp_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected glyphs from plain arithmetic on the sampled value
   task automatic model(input longint v, input int w, input bit hex, input bit add, input bit sub);
      bit     neg;
      longint mag, t;
      int     base, nd, lim;
      int     d [8];
      neg  = !hex && sub && !add && v[w-1];
      mag  = neg ? ((longint'(1) << w) - v) : v;
      base = hex ? 16 : 10;
      t    = mag;
      for (int k = 0; k < 8; k++) begin
         d[k] = int'(t % base);
         t    = t / base;
      end
      nd = 1;
      for (int k = 0; k < 8; k++) if (d[k] != 0) nd = k + 1;
      lim     = neg ? D - 1 : D;
      exp_ovf = (nd > lim);
      for (int i = 0; i < D; i++) begin
`ifdef SEG_LZB_EN
         if (i < nd)                  exp_g[i] = gtab[d[i]];
         else if (neg && i == nd)     exp_g[i] = 7'b0111111;
         else                         exp_g[i] = 7'b1111111;
`else
         if (neg && i == D - 1)       exp_g[i] = 7'b0111111;
         else                         exp_g[i] = gtab[d[i]];
`endif
         if (exp_ovf) exp_g[i] = 7'b0000110;
      end
   endtask

   task automatic scan_check();
      logic [3:0] seen;
      int         idx;
      seen = 4'd0;
      @(negedge clk);
      for (int s = 0; s < D * SD; s++) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < D; i++) if (dig_m[i] == 1'b0) idx = i;
         check("dig_onehot", $countones(~dig_m), 1);
         if (idx >= 0) begin
            seen[idx] = 1'b1;
            check($sformatf("seg_dig%0d", idx), seg_m, exp_g[idx]);
         end
      end
      check("scan_cover", seen, 4'hF);
   endtask

   task automatic run_load(input bit sel, input longint v, input bit hex, input bit add,
                           input bit sub, input bit dbl);
      int n, lat;
      model(v, sel ? 16 : 8, hex, add, sub);
      lat = hex ? 1 : (sel ? 17 : 9);
      @(negedge clk);
      sel_t = sel; value_t = v[15:0]; hex_t = hex; add_t = add; sub_t = sub; load_t = 1'b1;
      @(negedge clk);
      if (dbl) begin
         value_t = 16'd99;
         @(negedge clk);
         lat = lat - 1;
      end
      load_t = 1'b0;
      n = 0;
      while (busy_m && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, lat);
      check("led", led_m, v[7:0]);
      check("ovf", ovf_m, exp_ovf);
      scan_check();
   endtask

   initial begin
      gtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
               7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      repeat (2) @(negedge clk);
      check("rst_dig", dig_m, 4'hF);
      check("rst_seg", seg_m, 7'h7F);
      check("rst_led", led_m, 8'h00);
      check("rst_busy", busy_m, 1'b0);
      check("rst_ovf", ovf_m, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("first_dig", dig_m, 4'b1110);
      check("first_seg", seg_m, 7'b1000000);

      run_load(1'b0, 27, 1'b0, 1'b1, 1'b0, 1'b0);
      run_load(1'b0, 8'hE2, 1'b0, 1'b0, 1'b1, 1'b0);
      run_load(1'b0, 8'hE2, 1'b0, 1'b1, 1'b1, 1'b0);
      run_load(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      run_load(1'b0, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b0);
      run_load(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_load(1'b0, 27, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a decimal conversion
      @(negedge clk);
      sel_t = 1'b0; value_t = 16'd200; hex_t = 1'b0; add_t = 1'b1; sub_t = 1'b0; load_t = 1'b1;
      @(negedge clk);
      load_t = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy_m, 1'b0);
      check("abort_led", led_m, 8'h00);
      check("abort_ovf", ovf_m, 1'b0);
      for (int i = 0; i < D; i++) exp_g[i] = 7'b1000000;
      scan_check();

      run_load(1'b1, 12345, 1'b0, 1'b1, 1'b0, 1'b0);
      run_load(1'b1, 42, 1'b0, 1'b1, 1'b0, 1'b0);
      run_load(1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
      run_load(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 16; r++) begin
         bit     sel;
         longint v;
         sel = 1'($urandom_range(0, 1));
         v   = sel ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 255));
         run_load(sel, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the board-level 4-digit seven-segment/LED "show" block.
- Samples an ALU result on request and converts it to hex or signed/unsigned decimal digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto a common active-low segment bus and mirrors the value on LEDs.
- Sits between the ALU output register and the board pins.

Parameters:
- DATA_W, 8: width of the sampled value.
- DIGITS, 4: number of multiplexed digits; dig[0] is the rightmost digit.
- SCAN_DIV, 50000: CLK cycles per digit slot.
- LED_W, 8: LED count; shows value[LED_W-1:0], zero-extended when LED_W > DATA_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- value  in  DATA_W  ALU result to display.
- load  in  1  sample request; accepted only when busy=0.
- hex_mode  in  1  1 = hex display, 0 = decimal.
- add  in  1  operation flag; selects unsigned decimal.
- sub  in  1  operation flag; selects signed (two's complement) decimal when add=0.
- dig  out  DIGITS  active-low one-hot digit enable.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- led  out  LED_W  latched value.
- busy  out  1  conversion in progress.
- ovf  out  1  latched value does not fit on DIGITS digits.

Behaviour:
- Reset values: dig = all 1, seg = 7'b1111111, led = 0, busy = 0, ovf = 0. Prescaler, scan index and FSM are 0/IDLE. Display register holds all digits '0'.
- RST mid-conversion aborts the conversion and discards any partial result.
- FSM states:
  - IDLE: load=1 latches value, hex_mode and sign mode; led updates on the next edge; busy=1.
  - HEX: 1 cycle.
  - DEC: exactly DATA_W shift cycles, then FIX.
  - FIX: 1 cycle, places sign/overflow, writes the display register atomically, then back to IDLE with busy=0.
- Latency from accept to display update: hex 1 cycle; decimal DATA_W+1 cycles.
- load while busy=1 is ignored; it is neither queued nor does it update led.
- Sign mode:
  - sub=1 and add=0: signed. A negative value converts its magnitude, and the minus glyph goes in digit DIGITS-1.
  - add=1 (including add=sub=1) or both 0: unsigned.
  - hex_mode ignores sign mode.
- Overflow: if the magnitude needs more than DIGITS digits (DIGITS-1 when negative), or hex needs more than DIGITS nibbles, then ovf=1 and every digit shows 'E'. ovf clears on the next completed conversion that fits.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count the index advances and wraps DIGITS-1 -> 0.
  - dig and seg are registered together so there is no ghosting.
  - The first edge after reset release drives dig = ~1 with digit 0's glyph.
  - Display-register updates take effect at the current slot without resetting the scan.
- Glyphs (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - minus = 0111111, blank = 1111111
- Unused high digits show '0'.

Optional Feature:
- SEG_LZB_EN defined: leading zeros above the most significant nonzero digit are blanked, and digit 0 always shows a glyph. A negative sign is placed immediately left of the most significant nonzero digit instead of in digit DIGITS-1. Overflow display is unchanged.
- SEG_LZB_EN undefined: no blanking; behaviour exactly as above.

Test Plan (SCAN_DIV=2 unless noted):
- RST high 2 cycles -> dig=1111, seg=1111111, led=00, busy=0. After release, dig=1110 and seg=1000000.
- value=27, add=1, hex_mode=0, load pulse -> busy high 9 cycles, led=0x1B. Digits 0..3 show 7,2,0,0 (1111000, 0100100, 1000000, 1000000) over one scan period.
- value=8'hE2, sub=1, add=0, decimal -> digits 0,3,0,minus. With SEG_LZB_EN: 0,3,minus,blank.
- value=8'hAB, hex_mode=1 -> busy exactly 1 cycle. Digits b,A,0,0 (0000011, 0001000, 1000000, 1000000).
- Two loads during a conversion:
  - Load 27 then load 99 one cycle later -> display shows 27 and led=0x1B.
  - Assert RST at shift cycle 4 -> display returns to 0000, busy=0.
- DATA_W=16, value=12345, decimal -> ovf=1, all four digits 0000110. Next load of 42 -> ovf=0, display 0042.
